trap_csr_unit: RTL and testbench
================================

TRAP_CSR_UNIT -- requirements
Module: trap_csr_unit

Interface
REQ-001 SHALL have parameter NUM_LIRQ, default 4, number of platform-local interrupt lines; legal range 1..16.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, reset value of mtvec.
REQ-003 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 reset_i  input  1  reset, asynchronous assert, active-low.
REQ-005 pc_i  input  32  PC of the instruction being trapped.
REQ-006 csr_r_addr_i  input  12  CSR read address.
REQ-007 csr_w_addr_i  input  12  CSR write address.
REQ-008 csr_wdata_i  input  32  CSR write data.
REQ-009 csr_wen_i  input  1  CSR write strobe, active-high.
REQ-010 meip_i, mtip_i, msip_i  input  1 each  external, timer and software interrupt levels.
REQ-011 lirq_i  input  NUM_LIRQ  local interrupt levels; bit i maps to cause 16+i.
REQ-012 exc_valid_i  input  1  synchronous exception request.
REQ-013 exc_cause_i  input  4  exception code.
REQ-014 mret_i  input  1  mret retiring.
REQ-015 csr_rdata_o  output  32  registered read data.
REQ-016 trap_o  output  1  one-cycle redirect pulse.
REQ-017 trap_addr_o  output  32  redirect target, valid while trap_o=1.
REQ-018 mepc_o  output  32  current mepc, for mret redirect.
REQ-019 irq_ack_o  output  1  one-cycle pulse when an interrupt (not an exception) is taken.
REQ-020 irq_id_o  output  5  cause code of the acknowledged interrupt, valid with irq_ack_o.

Function
REQ-021 FSM SHALL have states IDLE, TRAP, RET; reset state IDLE.
REQ-022 IDLE->TRAP SHALL occur when exc_valid_i=1, or mstatus.MIE=1 and any (mie & mip) bit is set; the cause is captured into mcause_buf.
REQ-023 Priority SHALL be: exception > MEI(11) > MSI(3) > MTI(7) > lirq, with the lowest lirq index first.
REQ-024 In TRAP: trap_o=1, mepc<=pc_i & ~3, mcause<=mcause_buf, MPIE<=MIE, MIE<=0; next state IDLE.
REQ-025 trap_addr_o SHALL be {mtvec[31:2],2'b00}, plus 4*cause when mtvec[0]=1 and the cause is an interrupt.
REQ-026 IDLE->RET SHALL occur on mret_i when no trap is pending; RET: MIE<=MPIE, MPIE<=1; next state IDLE.
REQ-027 mip SHALL be a registered copy of the interrupt inputs, sampled every cycle; mip is read-only and writes to it are ignored.
REQ-028 CSR writes (0x300 MIE/MPIE only, 0x304 bits 3/7/11/16+, 0x305, 0x340, 0x341, 0x342) SHALL take effect next edge.
REQ-029 Trap commit SHALL win over a same-cycle CSR write to mstatus/mepc/mcause; the write is dropped.
REQ-030 An mret arriving in the same cycle as a trap request SHALL be ignored.
REQ-031 csr_rdata_o SHALL return the addressed CSR one cycle after csr_r_addr_i; unimplemented addresses SHALL read 0.
REQ-032 mcause bit 31 SHALL be 1 for interrupts and 0 for exceptions.

Reset
REQ-033 On reset: outputs 0, mstatus=0 except MPP=2'b11, mie/mip/mepc/mcause/mscratch=0, mtvec=RESET_VEC.

Configuration
REQ-034 With TRAP_CSR_MCYCLE_EN defined, a 64-bit mcycle SHALL increment every cycle and be readable/writable at 0xB00/0xB80, with the write taking priority over the increment.
REQ-035 Without TRAP_CSR_MCYCLE_EN, 0xB00/0xB80 SHALL read 0 and no counter logic SHALL exist.

Structure
REQ-036 Package trap_csr_pkg SHALL hold the CSR address constants, cause codes and the FSM state typedef.
REQ-037 Sub-module irq_prio_enc SHALL implement the REQ-023 priority selection.

Verification
REQ-038 Bench SHALL cover: mtvec=0x101, MIE=1, mie[11]=1, meip_i=1 -> trap_o, trap_addr_o=0x12C, mcause=0x8000000B, irq_id_o=11.
REQ-039 Bench SHALL cover: NUM_LIRQ=4, lirq_i=4'b1010, mie[17]=mie[19]=1 -> mcause=0x80000011.
REQ-040 Bench SHALL cover: exc_valid_i=1, exc_cause_i=2 with meip pending -> mcause=2, irq_ack_o=0, trap_addr_o=mtvec base.
REQ-041 Bench SHALL cover: trap from pc_i=0x202 followed by mret -> mepc_o=0x200, MIE restored to 1, MPIE=1.
REQ-042 Bench SHALL cover: CSR write 0x341=0x55 in the trap commit cycle -> mepc=pc_i & ~3 and the write is lost.
REQ-043 Bench SHALL cover: reset_i asserted in TRAP -> state IDLE and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/trap_csr_pkg.sv
// Shared CSR addresses, interrupt cause codes and trap FSM state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package trap_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [4:0] CAUSE_MSI       = 5'd3;
    localparam logic [4:0] CAUSE_MTI       = 5'd7;
    localparam logic [4:0] CAUSE_MEI       = 5'd11;
    localparam logic [4:0] CAUSE_LIRQ_BASE = 5'd16;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_RET
    } trap_state_e;

    // Bits of mie/mip that exist for a given number of local interrupt lines.
    function automatic logic [31:0] irq_mask(input int num_lirq);
        logic [31:0] m;
        m = 32'h0000_0888;
        for (int i = 0; i < num_lirq; i++) begin
            m[16+i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Picks the highest-priority pending interrupt: MEI > MSI > MTI > lirq (lowest index first).
// Latency: combinational.
// Backpressure: none.
module irq_prio_enc
    import trap_csr_pkg::*;
#(
    parameter int NUM_LIRQ = 4
) (
    input  logic                mei,
    input  logic                msi,
    input  logic                mti,
    input  logic [NUM_LIRQ-1:0] lirq,
    output logic                vld,
    output logic [4:0]          id
);

    // Later assignments override earlier ones, so lowest priority is evaluated first.
    always_comb begin
        vld = 1'b0;
        id  = '0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
            if (lirq[i]) begin
                vld = 1'b1;
                id  = CAUSE_LIRQ_BASE + 5'(i);
            end
        end
        if (mti) begin
            vld = 1'b1;
            id  = CAUSE_MTI;
        end
        if (msi) begin
            vld = 1'b1;
            id  = CAUSE_MSI;
        end
        if (mei) begin
            vld = 1'b1;
            id  = CAUSE_MEI;
        end
    end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode trap CSRs and trap/mret sequencer; 64-bit mcycle when TRAP_CSR_MCYCLE_EN is defined.
// Latency: trap taken one cycle after request, CSR read data one cycle after address.
// Backpressure: none; trap_o is a single-cycle redirect pulse.
module trap_csr_unit
    import trap_csr_pkg::*;
#(
    parameter int          NUM_LIRQ  = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         pc_i,
    input  logic [11:0]         csr_r_addr_i,
    input  logic [11:0]         csr_w_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic                csr_wen_i,
    input  logic                meip_i,
    input  logic                mtip_i,
    input  logic                msip_i,
    input  logic [NUM_LIRQ-1:0] lirq_i,
    input  logic                exc_valid_i,
    input  logic [3:0]          exc_cause_i,
    input  logic                mret_i,
    output logic [31:0]         csr_rdata_o,
    output logic                trap_o,
    output logic [31:0]         trap_addr_o,
    output logic [31:0]         mepc_o,
    output logic                irq_ack_o,
    output logic [4:0]          irq_id_o
);

    localparam logic [31:0] MIE_MASK = irq_mask(NUM_LIRQ);

    trap_state_e state_q, state_d;

    logic        mstatus_mie_q, mstatus_mpie_q;
    logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mcause_buf_q;
    logic [31:0] csr_rdata_q, rdata_d;
    logic [31:0] irq_in, pending, cause_sel, vec_base, vec_addr;
    logic        irq_vld, trap_req, trap_commit, ret_commit;
    logic [4:0]  irq_id;

    always_comb begin
        irq_in                      = '0;
        irq_in[CAUSE_MEI]           = meip_i;
        irq_in[CAUSE_MTI]           = mtip_i;
        irq_in[CAUSE_MSI]           = msip_i;
        irq_in[16 +: NUM_LIRQ]      = lirq_i;
    end

    assign pending = mie_q & mip_q;

    irq_prio_enc #(
        .NUM_LIRQ (NUM_LIRQ)
    ) u_prio (
        .mei  (pending[CAUSE_MEI]),
        .msi  (pending[CAUSE_MSI]),
        .mti  (pending[CAUSE_MTI]),
        .lirq (pending[16 +: NUM_LIRQ]),
        .vld  (irq_vld),
        .id   (irq_id)
    );

    assign trap_req  = exc_valid_i || (mstatus_mie_q && irq_vld);
    assign cause_sel = exc_valid_i ? {28'b0, exc_cause_i} : {1'b1, 26'b0, irq_id};

    assign vec_base = {mtvec_q[31:2], 2'b00};
    assign vec_addr = (mtvec_q[0] && mcause_buf_q[31])
                    ? vec_base + {25'b0, mcause_buf_q[4:0], 2'b00}
                    : vec_base;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A pending trap always beats mret in IDLE.
    always_comb begin
        state_d     = state_q;
        trap_o      = 1'b0;
        trap_addr_o = '0;
        irq_ack_o   = 1'b0;
        irq_id_o    = '0;
        case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    state_d = ST_TRAP;
                end else if (mret_i) begin
                    state_d = ST_RET;
                end
            end
            ST_TRAP: begin
                trap_o      = 1'b1;
                trap_addr_o = vec_addr;
                irq_ack_o   = mcause_buf_q[31];
                irq_id_o    = mcause_buf_q[31] ? mcause_buf_q[4:0] : 5'd0;
                state_d     = ST_IDLE;
            end
            ST_RET: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign trap_commit = (state_q == ST_TRAP);
    assign ret_commit  = (state_q == ST_RET);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mcause_buf_q <= '0;
        end else if (state_q == ST_IDLE && trap_req) begin
            mcause_buf_q <= cause_sel;
        end
    end

    // Trap and mret updates take precedence; a colliding CSR write is dropped.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            if (trap_commit) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (ret_commit) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (csr_wen_i && csr_w_addr_i == CSR_MSTATUS) begin
                mstatus_mie_q  <= csr_wdata_i[MSTATUS_MIE];
                mstatus_mpie_q <= csr_wdata_i[MSTATUS_MPIE];
            end

            if (trap_commit) begin
                mepc_q <= pc_i & ~32'h3;
            end else if (csr_wen_i && csr_w_addr_i == CSR_MEPC) begin
                mepc_q <= csr_wdata_i & ~32'h3;
            end

            if (trap_commit) begin
                mcause_q <= mcause_buf_q;
            end else if (csr_wen_i && csr_w_addr_i == CSR_MCAUSE) begin
                mcause_q <= csr_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= RESET_VEC;
            mscratch_q <= '0;
        end else begin
            mip_q <= irq_in;
            if (csr_wen_i) begin
                case (csr_w_addr_i)
                    CSR_MIE:      mie_q      <= csr_wdata_i & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= csr_wdata_i;
                    CSR_MSCRATCH: mscratch_q <= csr_wdata_i;
                    default: ;
                endcase
            end
        end
    end

`ifdef TRAP_CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;

    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (csr_wen_i && csr_w_addr_i == CSR_MCYCLE) begin
            mcycle_d[31:0] = csr_wdata_i;
        end
        if (csr_wen_i && csr_w_addr_i == CSR_MCYCLEH) begin
            mcycle_d[63:32] = csr_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        case (csr_r_addr_i)
            CSR_MSTATUS:  rdata_d = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            CSR_MIE:      rdata_d = mie_q;
            CSR_MIP:      rdata_d = mip_q;
            CSR_MTVEC:    rdata_d = mtvec_q;
            CSR_MSCRATCH: rdata_d = mscratch_q;
            CSR_MEPC:     rdata_d = mepc_q;
            CSR_MCAUSE:   rdata_d = mcause_q;
`ifdef TRAP_CSR_MCYCLE_EN
            CSR_MCYCLE:   rdata_d = mcycle_q[31:0];
            CSR_MCYCLEH:  rdata_d = mcycle_q[63:32];
`endif
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            csr_rdata_q <= '0;
        end else begin
            csr_rdata_q <= rdata_d;
        end
    end

    assign csr_rdata_o = csr_rdata_q;
    assign mepc_o      = mepc_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: CSR access, interrupt/exception traps, mret and async reset.
module tb_trap_csr_unit;

    localparam int          NUM_LIRQ  = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0080;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [31:0]         pc_i;
    logic [11:0]         csr_r_addr_i;
    logic [11:0]         csr_w_addr_i;
    logic [31:0]         csr_wdata_i;
    logic                csr_wen_i;
    logic                meip_i, mtip_i, msip_i;
    logic [NUM_LIRQ-1:0] lirq_i;
    logic                exc_valid_i;
    logic [3:0]          exc_cause_i;
    logic                mret_i;
    logic [31:0]         csr_rdata_o;
    logic                trap_o;
    logic [31:0]         trap_addr_o;
    logic [31:0]         mepc_o;
    logic                irq_ack_o;
    logic [4:0]          irq_id_o;

    typedef struct {
        logic [31:0] addr;
        logic        ack;
        logic [4:0]  id;
    } trap_exp_t;

    logic [31:0] rd_q[$];
    trap_exp_t   trap_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    trap_csr_unit #(
        .NUM_LIRQ  (NUM_LIRQ),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .pc_i         (pc_i),
        .csr_r_addr_i (csr_r_addr_i),
        .csr_w_addr_i (csr_w_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_wen_i    (csr_wen_i),
        .meip_i       (meip_i),
        .mtip_i       (mtip_i),
        .msip_i       (msip_i),
        .lirq_i       (lirq_i),
        .exc_valid_i  (exc_valid_i),
        .exc_cause_i  (exc_cause_i),
        .mret_i       (mret_i),
        .csr_rdata_o  (csr_rdata_o),
        .trap_o       (trap_o),
        .trap_addr_o  (trap_addr_o),
        .mepc_o       (mepc_o),
        .irq_ack_o    (irq_ack_o),
        .irq_id_o     (irq_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_w_addr_i = addr;
        csr_wdata_i  = data;
        csr_wen_i    = 1'b1;
        tick();
        csr_wen_i    = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        csr_r_addr_i = addr;
        rd_q.push_back(exp);
        tick();
        e = rd_q.pop_front();
        check(tag, csr_rdata_o, e);
    endtask

    task automatic expect_trap(input logic [31:0] addr, input logic ack, input logic [4:0] id);
        trap_exp_t t;
        t.addr = addr;
        t.ack  = ack;
        t.id   = id;
        trap_q.push_back(t);
    endtask

    task automatic wait_trap(input string tag);
        trap_exp_t t;
        int n = 0;
        while (!trap_o && n < 10) begin
            tick();
            n++;
        end
        t = trap_q.pop_front();
        check({tag, "_trap"}, {31'b0, trap_o}, 32'd1);
        check({tag, "_addr"}, trap_addr_o, t.addr);
        check({tag, "_ack"}, {31'b0, irq_ack_o}, {31'b0, t.ack});
        check({tag, "_id"}, {27'b0, irq_id_o}, {27'b0, t.id});
    endtask

    initial begin
        reset_i      = 1'b0;
        pc_i         = '0;
        csr_r_addr_i = '0;
        csr_w_addr_i = '0;
        csr_wdata_i  = '0;
        csr_wen_i    = 1'b0;
        meip_i       = 1'b0;
        mtip_i       = 1'b0;
        msip_i       = 1'b0;
        lirq_i       = '0;
        exc_valid_i  = 1'b0;
        exc_cause_i  = '0;
        mret_i       = 1'b0;

        tick();
        tick();
        check("rst_trap", {31'b0, trap_o}, 32'd0);
        check("rst_rdata", csr_rdata_o, 32'd0);
        check("rst_mepc", mepc_o, 32'd0);
        check("rst_ack", {31'b0, irq_ack_o}, 32'd0);
        reset_i = 1'b1;
        tick();

        csr_read("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_read("rst_mtvec", 12'h305, RESET_VEC);
        csr_read("rst_mie", 12'h304, 32'h0);
        csr_read("unimpl", 12'h7C0, 32'h0);

        csr_write(12'h340, 32'hDEAD_BEEF);
        csr_read("mscratch", 12'h340, 32'hDEAD_BEEF);
        csr_write(12'h344, 32'hFFFF_FFFF);
        csr_read("mip_ro", 12'h344, 32'h0);
        csr_write(12'h304, 32'hFFFF_FFFF);
        csr_read("mie_mask", 12'h304, 32'h000F_0888);

`ifdef TRAP_CSR_MCYCLE_EN
        csr_write(12'hB00, 32'h0000_0010);
        csr_read("mcycle_lo", 12'hB00, 32'h0000_0010);
        csr_read("mcycle_hi", 12'hB80, 32'h0);
`else
        csr_read("mcycle_lo", 12'hB00, 32'h0);
        csr_read("mcycle_hi", 12'hB80, 32'h0);
`endif

        // Vectored MEI
        csr_write(12'h305, 32'h0000_0101);
        csr_write(12'h304, 32'h0000_0800);
        csr_write(12'h300, 32'h0000_0008);
        pc_i   = 32'h0000_1000;
        meip_i = 1'b1;
        expect_trap(32'h0000_012C, 1'b1, 5'd11);
        wait_trap("mei");
        meip_i = 1'b0;
        tick();
        check("mei_pulse", {31'b0, trap_o}, 32'd0);
        check("mei_ack_pulse", {31'b0, irq_ack_o}, 32'd0);
        check("mei_mepc_o", mepc_o, 32'h0000_1000);
        csr_read("mei_mcause", 12'h342, 32'h8000_000B);
        csr_read("mei_mstatus", 12'h300, 32'h0000_1880);

        // Local interrupts: lowest enabled index wins
        csr_write(12'h304, 32'h000A_0000);
        csr_write(12'h300, 32'h0000_0008);
        lirq_i = 4'b1010;
        expect_trap(32'h0000_0144, 1'b1, 5'd17);
        wait_trap("lirq");
        lirq_i = '0;
        tick();
        csr_read("lirq_mcause", 12'h342, 32'h8000_0011);

        // Exception beats pending MEI
        csr_write(12'h304, 32'h0000_0800);
        csr_write(12'h300, 32'h0000_0008);
        meip_i = 1'b1;
        tick();
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd2;
        expect_trap(32'h0000_0100, 1'b0, 5'd0);
        tick();
        exc_valid_i = 1'b0;
        wait_trap("exc");
        meip_i = 1'b0;
        tick();
        csr_read("exc_mcause", 12'h342, 32'h0000_0002);

        // Trap from misaligned PC, colliding mepc write, then mret
        csr_write(12'h300, 32'h0000_0008);
        pc_i        = 32'h0000_0202;
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd0;
        expect_trap(32'h0000_0100, 1'b0, 5'd0);
        tick();
        exc_valid_i = 1'b0;
        wait_trap("pc202");
        csr_w_addr_i = 12'h341;
        csr_wdata_i  = 32'h0000_0055;
        csr_wen_i    = 1'b1;
        tick();
        csr_wen_i    = 1'b0;
        check("wr_lost_mepc_o", mepc_o, 32'h0000_0200);
        csr_read("wr_lost_mepc", 12'h341, 32'h0000_0200);
        csr_read("pc202_mstatus", 12'h300, 32'h0000_1880);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        tick();
        csr_read("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_mepc_o", mepc_o, 32'h0000_0200);

        // mret colliding with a trap request is ignored
        pc_i        = 32'h0000_0300;
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd3;
        mret_i      = 1'b1;
        expect_trap(32'h0000_0100, 1'b0, 5'd0);
        tick();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        wait_trap("mret_vs_trap");
        tick();
        csr_read("mret_vs_trap_mstatus", 12'h300, 32'h0000_1880);
        csr_read("mret_vs_trap_mepc", 12'h341, 32'h0000_0300);

        // Asynchronous reset while in TRAP
        csr_r_addr_i = 12'h305;
        exc_valid_i  = 1'b1;
        exc_cause_i  = 4'd1;
        tick();
        exc_valid_i  = 1'b0;
        check("pre_rst_trap", {31'b0, trap_o}, 32'd1);
        check("pre_rst_rdata", csr_rdata_o, 32'h0000_0101);
        #2;
        reset_i = 1'b0;
        #1;
        check("arst_trap", {31'b0, trap_o}, 32'd0);
        check("arst_addr", trap_addr_o, 32'd0);
        check("arst_rdata", csr_rdata_o, 32'd0);
        check("arst_mepc", mepc_o, 32'd0);
        check("arst_ack", {31'b0, irq_ack_o}, 32'd0);
        check("arst_id", {27'b0, irq_id_o}, 32'd0);
        tick();
        reset_i = 1'b1;
        tick();
        csr_read("arst_mtvec", 12'h305, RESET_VEC);
        csr_read("arst_mstatus", 12'h300, 32'h0000_1800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
